clk_period_meter: RTL and testbench

Measures the period of an asynchronous square-wave input in `inclk` cycles and reports it as a full period and as a half-period divisor. The half-period divisor is directly loadable as the `clk_divisor` input of the team's clock divider, so a measured tone or tick can be regenerated. The block sits beside the divider in the audio/LED timing path as its inverse: frequency in, divisor out. It also flags lock on a stable input and a timeout on a missing or stopped input.

---
 rtl/clk_period_meter.sv | 114 +++++++++++
 tb/tb_clk_period_meter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures the period of an asynchronous square wave in inclk cycles
// Reports full and half period (a divider-loadable divisor), lock on a stable input and a sticky timeout.
module clk_period_meter #(
  parameter logic [31:0] TIMEOUT = 32'd50_000_000,
  parameter logic [31:0] TOL     = 32'd2
) (
  input  logic        inclk,
  input  logic        reset,
  input  logic        sig_in,
  input  logic        meas_en,
  output logic [31:0] period,
  output logic [31:0] half_period,
  output logic        valid,
  output logic        locked,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t      state;
  logic        s1;
  logic        s2;
  logic        s3;
  logic        rise;
  logic [31:0] cnt;
  logic [31:0] prev;
  logic [31:0] diff;
  logic        have_prev;

  always_ff @(posedge inclk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign diff = (cnt >= prev) ? (cnt - prev) : (prev - cnt);

  always_ff @(posedge inclk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 32'd0;
      prev        <= 32'd0;
      have_prev   <= 1'b0;
      period      <= 32'd0;
      half_period <= 32'd0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!meas_en) begin
        // Disable overrides any rise or timeout; the last result stays visible.
        state     <= IDLE;
        cnt       <= 32'd0;
        have_prev <= 1'b0;
        locked    <= 1'b0;
        timeout   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
            cnt   <= 32'd0;
          end
          ARM: begin
            if (rise) begin
              state     <= MEASURE;
              cnt       <= 32'd1;
              have_prev <= 1'b0;
            end
          end
          MEASURE: begin
            if (rise) begin
              period      <= cnt;
              half_period <= cnt >> 1;
              prev        <= cnt;
              have_prev   <= 1'b1;
              valid       <= 1'b1;
              timeout     <= 1'b0;
              cnt         <= 32'd1;
              if (have_prev) begin
                locked <= (diff <= TOL);
              end
            end else if (cnt >= TIMEOUT) begin
              // A rise on the threshold cycle is taken above, so it always wins.
              state     <= ARM;
              cnt       <= 32'd0;
              have_prev <= 1'b0;
              timeout   <= 1'b1;
              locked    <= 1'b0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 32'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - randomized check of clk_period_meter against a timestamp-based model
// Three instances with different TIMEOUT/TOL share one stimulus stream.
module tb_clk_period_meter;

  logic        inclk = 1'b0;
  logic        reset = 1'b0;
  logic        sig_in = 1'b0;
  logic        meas_en = 1'b0;
  logic [31:0] per [3];
  logic [31:0] half [3];
  logic        vld [3];
  logic        lck [3];
  logic        tmo [3];

  int tests = 0;
  int fails = 0;

  always #5 inclk = ~inclk;

  clk_period_meter #(.TIMEOUT(32'd120), .TOL(32'd2)) u_a (
    .inclk(inclk), .reset(reset), .sig_in(sig_in), .meas_en(meas_en),
    .period(per[0]), .half_period(half[0]), .valid(vld[0]), .locked(lck[0]), .timeout(tmo[0]));
  clk_period_meter #(.TIMEOUT(32'd120), .TOL(32'd3)) u_b (
    .inclk(inclk), .reset(reset), .sig_in(sig_in), .meas_en(meas_en),
    .period(per[1]), .half_period(half[1]), .valid(vld[1]), .locked(lck[1]), .timeout(tmo[1]));
  clk_period_meter #(.TIMEOUT(32'd50), .TOL(32'd2)) u_c (
    .inclk(inclk), .reset(reset), .sig_in(sig_in), .meas_en(meas_en),
    .period(per[2]), .half_period(half[2]), .valid(vld[2]), .locked(lck[2]), .timeout(tmo[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: timestamps of synchronized rises; period is the edge distance between them.
  function automatic longint to_of(input int i);
    return (i == 2) ? 64'd50 : 64'd120;
  endfunction
  function automatic longint tol_of(input int i);
    return (i == 1) ? 64'd3 : 64'd2;
  endfunction

  longint      edge_no;
  bit          hist [3];
  int          mode [3];     // 0 disabled, 1 waiting for first rise, 2 timing
  longint      t0 [3];
  bit          havep [3];
  longint      prevp [3];
  logic [31:0] mper [3];
  logic [31:0] mhalf [3];
  bit          mval [3];
  bit          mlock [3];
  bit          mto [3];

  task automatic model_step(input int i, input bit r);
    longint el;
    longint d;
    mval[i] = 1'b0;
    if (!meas_en) begin
      mode[i] = 0; mlock[i] = 1'b0; mto[i] = 1'b0;
    end else if (mode[i] == 0) begin
      mode[i] = 1;
    end else if (mode[i] == 1) begin
      if (r) begin mode[i] = 2; t0[i] = edge_no; havep[i] = 1'b0; end
    end else begin
      el = edge_no - t0[i];
      if (r) begin
        mper[i] = 32'(el); mhalf[i] = 32'(el / 2); mval[i] = 1'b1; mto[i] = 1'b0;
        d = (el > prevp[i]) ? el - prevp[i] : prevp[i] - el;
        if (havep[i]) mlock[i] = (d <= tol_of(i));
        prevp[i] = el; havep[i] = 1'b1; t0[i] = edge_no;
      end else if (el >= to_of(i)) begin
        mode[i] = 1; mto[i] = 1'b1; mlock[i] = 1'b0;
      end
    end
  endtask

  always @(posedge inclk or negedge reset) begin
    bit r;
    if (!reset) begin
      edge_no = 0;
      for (int k = 0; k < 3; k++) hist[k] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        mode[i] = 0; t0[i] = 0; havep[i] = 1'b0; prevp[i] = 0; mper[i] = '0;
        mhalf[i] = '0; mval[i] = 1'b0; mlock[i] = 1'b0; mto[i] = 1'b0;
      end
    end else begin
      edge_no++;
      r = hist[1] && !hist[2];
      for (int i = 0; i < 3; i++) model_step(i, r);
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = sig_in;
    end
  end

  always @(negedge inclk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.period", i), per[i], mper[i]);
      check($sformatf("u%0d.half_period", i), half[i], mhalf[i]);
      check($sformatf("u%0d.valid", i), 32'(vld[i]), 32'(mval[i]));
      check($sformatf("u%0d.locked", i), 32'(lck[i]), 32'(mlock[i]));
      check($sformatf("u%0d.timeout", i), 32'(tmo[i]), 32'(mto[i]));
    end
  end

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      sig_in = 1'b1;
      repeat (hi) tick();
      sig_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  initial begin
    int d;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("reset_period", per[i], 32'd0);
      check("reset_flags", {29'd0, vld[i], lck[i], tmo[i]}, 32'd0);
    end
    reset = 1'b1;
    tick();
    meas_en = 1'b1;

    wave(5, 5, 4);
    check("p10_period", per[0], 32'd10);
    check("p10_half", half[0], 32'd5);
    check("p10_locked", 32'(lck[0]), 32'd1);

    wave(7, 7, 4);
    check("div7_period", per[0], 32'd14);
    check("div7_half", half[0], 32'd7);

    d = int'(half[0]);
    wave(d, d, 4);
    check("feedback_period", per[0], 32'd14);

    wave(5, 4, 4);
    check("p9_half", half[0], 32'd4);

    repeat (3) begin
      wave(50, 50, 1);
      wave(52, 51, 1);
    end
    check("alt_tol2_locked", 32'(lck[0]), 32'd0);
    check("alt_tol3_locked", 32'(lck[1]), 32'd1);

    wave(10, 10, 3);
    repeat (70) tick();
    check("to_flag", 32'(tmo[2]), 32'd1);
    check("to_locked", 32'(lck[2]), 32'd0);
    check("to_period_hold", per[2], 32'd20);
    wave(10, 10, 3);
    check("to_cleared", 32'(tmo[2]), 32'd0);

    sig_in = 1'b1;
    repeat (5) tick();
    sig_in = 1'b0;
    repeat (3) tick();
    meas_en = 1'b0;
    repeat (30) tick();
    check("drop_locked", 32'(lck[0]), 32'd0);
    check("drop_period_hold", per[0], 32'd20);
    meas_en = 1'b1;

    repeat (25) begin
      wave($urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) begin
        meas_en = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        meas_en = 1'b1;
      end
    end

    wave(10, 10, 3);
    sig_in = 1'b1;
    repeat (3) tick();
    @(negedge inclk);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("async_rst_period", per[i], 32'd0);
      check("async_rst_half", half[i], 32'd0);
      check("async_rst_flags", {29'd0, vld[i], lck[i], tmo[i]}, 32'd0);
    end
    tick();
    reset = 1'b1;
    wave(8, 8, 4);
    check("post_rst_period", per[0], 32'd16);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
